// File: rtl/div_clk_checker.sv
// Measures the high/low widths of a divided clock sampled in the clk_in domain,
// compares every full period with the programmed widths and tracks lock and errors.
module div_clk_checker #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_high,
    input  logic [CNT_W-1:0] exp_low,
    input  logic             err_clr,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] low_width,
    output logic             meas_valid,
    output logic             period_err,
    output logic             locked
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_MAX - 1'b1;
    localparam logic [3:0]       GOOD_MAX = 4'(LOCK_COUNT);

    state_t           r_state;
    logic             r_sig_q;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_high_width;
    logic [CNT_W-1:0] r_low_width;
    logic             r_meas_valid;
    logic             r_period_err;
    logic             r_locked;
    logic [3:0]       r_good_cnt;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_run_next;
    logic [CNT_W-1:0] w_high_next;
    logic [CNT_W-1:0] w_low_next;
    logic             w_meas_next;
    logic             w_err_next;
    logic             w_locked_next;
    logic [3:0]       w_good_next;
    logic             w_rise;
    logic             w_fall;
    logic             w_new_err;
    logic             w_match;
    logic             w_timeout;

    assign w_rise = sig_in & ~r_sig_q;
    assign w_fall = ~sig_in & r_sig_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sig_q      <= 1'b1;  // no false rise when sig_in is already high out of reset
            r_run_cnt    <= '0;
            r_high_width <= '0;
            r_low_width  <= '0;
            r_meas_valid <= 1'b0;
            r_period_err <= 1'b0;
            r_locked     <= 1'b0;
            r_good_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_sig_q      <= sig_in;
            r_run_cnt    <= w_run_next;
            r_high_width <= w_high_next;
            r_low_width  <= w_low_next;
            r_meas_valid <= w_meas_next;
            r_period_err <= w_err_next;
            r_locked     <= w_locked_next;
            r_good_cnt   <= w_good_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_high_next   = r_high_width;
        w_low_next    = r_low_width;
        w_meas_next   = 1'b0;
        w_locked_next = r_locked;
        w_good_next   = r_good_cnt;
        w_new_err     = 1'b0;
        w_match       = 1'b0;
        w_timeout     = 1'b0;

        if (w_rise || w_fall) begin
            w_run_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_run_cnt == CNT_MAX) begin
            w_run_next = CNT_MAX;
        end else begin
            w_run_next = r_run_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_high_next  = r_run_cnt;
                    w_state_next = ST_LOW;
                end else if (r_run_cnt >= CNT_TO) begin
                    w_timeout = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_low_next   = r_run_cnt;
                    w_meas_next  = 1'b1;
                    w_state_next = ST_HIGH;
                    w_match      = (r_high_width == exp_high) && (r_run_cnt == exp_low);
                    if (w_match) begin
                        if (r_good_cnt != GOOD_MAX) begin
                            w_good_next = r_good_cnt + 4'd1;
                        end
                        if (w_good_next == GOOD_MAX) begin
                            w_locked_next = 1'b1;
                        end
                    end else begin
                        w_good_next   = '0;
                        w_locked_next = 1'b0;
                        w_new_err     = 1'b1;
                    end
                end else if (r_run_cnt >= CNT_TO) begin
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A stuck level abandons the period; widths keep their last values.
        if (w_timeout) begin
            w_state_next  = ST_IDLE;
            w_good_next   = '0;
            w_locked_next = 1'b0;
            w_new_err     = 1'b1;
        end

        if (w_new_err) begin
            w_err_next = 1'b1;
        end else if (err_clr) begin
            w_err_next = 1'b0;
        end else begin
            w_err_next = r_period_err;
        end
    end

    assign high_width = r_high_width;
    assign low_width  = r_low_width;
    assign meas_valid = r_meas_valid;
    assign period_err = r_period_err;
    assign locked     = r_locked;

endmodule

// File: doc/div_clk_checker.md
Name: div_clk_checker

Overview:
Downstream consumer of the clock divider outputs (clk_div_2/4/5/8/16/28). It samples one divided clock as a data signal in the clk_in domain and measures its high and low widths in clk_in cycles. It compares each complete period against programmed expected widths and reports measurements, a sticky error and a lock status. It is used on-chip and in benches to prove divider correctness and to catch glitches.

Parameters:
CNT_W, 8, width of the width counters and of the exp/measured width ports
LOCK_COUNT, 4, consecutive matching periods required before locked asserts (1..15)

Ports:
clk_in  input  1  system clock, the same clock that drives the divider
rst  input  1  synchronous active-high reset
sig_in  input  1  divided clock under test, sampled on posedge clk_in
exp_high  input  CNT_W  expected high width in clk_in cycles, must be >=1
exp_low  input  CNT_W  expected low width in clk_in cycles, must be >=1
err_clr  input  1  one-cycle pulse that clears period_err
high_width  output  CNT_W  last measured high width
low_width  output  CNT_W  last measured low width
meas_valid  output  1  one-cycle pulse: a full period has been measured and compared
period_err  output  1  sticky: a mismatch or timeout has occurred
locked  output  1  LOCK_COUNT consecutive matching periods have been seen, with no error since

Behaviour:
- Clock and reset: one clock, clk_in, with synchronous active-high reset rst.
- Reset: high_width=0, low_width=0, meas_valid=0, period_err=0, locked=0, good_cnt=0, run_cnt=0, FSM=IDLE, sig_q=1.
  - Resetting sig_q to 1 prevents a false rise if sig_in is already high out of reset.
- Edge detect:
  - sig_q <= sig_in every cycle.
  - rise = sig_in & ~sig_q; fall = ~sig_in & sig_q.
- run_cnt counts clk_in cycles spent at the current level.
  - Loaded with 1 on an edge-detect cycle, otherwise incremented.
  - Saturates at 2^CNT_W-1.
- FSM states IDLE, HIGH, LOW:
  - IDLE: wait for rise; ignore fall. On rise: run_cnt<=1, go to HIGH. The partial period after reset or after a timeout is discarded.
  - HIGH: on fall: high_width<=run_cnt, run_cnt<=1, go to LOW.
  - LOW: on rise: low_width<=run_cnt, run_cnt<=1, meas_valid<=1 for one cycle, go to HIGH, then compare.
    - Compare uses the new low width and the latched high_width against exp_low and exp_high, as sampled in that cycle.
- Compare result:
  - Match: good_cnt increments, saturating at LOCK_COUNT. locked<=1 when the incremented good_cnt equals LOCK_COUNT.
  - Mismatch: good_cnt<=0, locked<=0, period_err<=1.
- Timeout: run_cnt reaching 2^CNT_W-1 in HIGH or LOW means the signal is stuck.
  - Sets period_err<=1, locked<=0 and good_cnt<=0, and returns the FSM to IDLE.
  - meas_valid does not pulse; widths keep their old values.
- Error clear: err_clr clears period_err.
  - If a new error is detected in the same cycle, period_err stays 1.
  - err_clr does not affect locked or good_cnt.
- Latency: all outputs are registered.
  - meas_valid, low_width and locked update on the clk_in edge at which sig_in is first sampled high after a low phase.
  - meas_valid is high during the following cycle only.
- Width convention: sampled widths equal the divider's widths in clk_in cycles. Examples:
  - clk_div_2 gives 1/1.
  - clk_div_4 gives 2/2.
  - clk_div_28 gives 14/14.
  - clk_div_5 gives whatever duty the divider produces, and exp_* must be programmed to match.
- exp_* may change at any time; the new values take effect at the next compare.
- Reset mid-operation: everything returns to reset values next cycle and the in-flight period is discarded.

Test Plan:
1. Drive sig_in from clock_gen clk_div_4, exp_high=2, exp_low=2.
   - Every meas_valid shows high_width=2, low_width=2.
   - locked rises on the 4th meas_valid; period_err stays 0.
2. Drive clk_div_28 with exp 14/14, then with exp 13/14.
   - First run: locked after 4 periods.
   - Second run: period_err=1 on the first meas_valid, locked stays 0, widths report 14/14.
3. Glitch: hand-driven 14/14 wave, locked=1, then insert a 1-cycle low pulse mid-high.
   - Next meas_valid reports high_width=5 (for a split at cycle 5), low_width=1; period_err=1, locked=0.
   - The following meas_valid reports the mismatching width of the remainder of the split high phase.
   - locked returns after 4 clean periods; err_clr then clears period_err.
4. Timeout with CNT_W=8: sig_in held high 300 cycles after a rise.
   - period_err=1 once run_cnt reaches 255, and the FSM goes to IDLE.
   - The next partial high is ignored and no meas_valid appears until a full low+high period completes.
5. Assert rst for 1 cycle in the middle of a high phase of clk_div_8.
   - All outputs are 0 the next cycle.
   - The first meas_valid comes only after the next complete rise-to-rise period and reports 4/4.
6. Assert err_clr in the same cycle as a mismatching compare: period_err remains 1.
   - Assert err_clr alone on a later cycle: period_err goes to 0 and locked is unaffected.
